// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - CPU-to-memory strobe/data bundle for mem_responder
interface mem_responder_if #(
    parameter int ADDR_W = 9
);
    logic              Read;
    logic              Write;
    logic [ADDR_W-1:0] Address;
    logic [31:0]       DataIn;
    logic [31:0]       DataOut;
    logic              Ready;
    logic              Busy;
    logic              Collision;
    logic              Overrun;

    modport master (
        output Read, Write, Address, DataIn,
        input  DataOut, Ready, Busy, Collision, Overrun
    );

    modport slave (
        input  Read, Write, Address, DataIn,
        output DataOut, Ready, Busy, Collision, Overrun
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-stated 32-bit word memory answering edge-triggered read/write strobes
module mem_responder #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           Clock,
    input  logic           Reset,
    mem_responder_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_DONE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state;
    logic [3:0]        count;
    logic              read_d;
    logic              write_d;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_data;
    logic [31:0]       data_out;
    logic              ready;
    logic              busy;
    logic              collision;
    logic              overrun;
    logic              rd_edge;
    logic              wr_edge;

    // Contents survive reset, so the array starts from zero only once.
    logic [31:0] mem [2**ADDR_W] = '{default: 32'h0};

    assign rd_edge = bus.Read & ~read_d;
    assign wr_edge = bus.Write & ~write_d;

    assign bus.DataOut   = data_out;
    assign bus.Ready     = ready;
    assign bus.Busy      = busy;
    assign bus.Collision = collision;
    assign bus.Overrun   = overrun;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_IDLE;
            count     <= 4'd0;
            read_d    <= 1'b0;
            write_d   <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= 32'h0;
            data_out  <= 32'h0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            collision <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            read_d    <= bus.Read;
            write_d   <= bus.Write;
            ready     <= 1'b0;
            collision <= 1'b0;

            // Any edge outside IDLE, including the DONE cycle, is dropped.
            if (state != ST_IDLE && (rd_edge || wr_edge))
                overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (rd_edge ^ wr_edge) begin
                        lat_write <= wr_edge;
                        lat_addr  <= bus.Address;
                        lat_data  <= bus.DataIn;
                        count     <= WAIT_INIT;
                        busy      <= 1'b1;
                        state     <= (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                    end else if (rd_edge && wr_edge) begin
                        collision <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    count <= count - 4'd1;
                    if (count == 4'd1)
                        state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (!lat_write)
                        data_out <= mem[lat_addr];
                    ready <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset && state == ST_ACCESS && lat_write)
            mem[lat_addr] <= lat_data;
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized model-based bench for mem_responder at two wait settings
module tb_mem_responder;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   din;

    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(AW)) bus2 ();
    mem_responder_if #(.ADDR_W(AW)) bus0 ();

    assign bus2.Read    = rd;
    assign bus2.Write   = wr;
    assign bus2.Address = addr;
    assign bus2.DataIn  = din;
    assign bus0.Read    = rd;
    assign bus0.Write   = wr;
    assign bus0.Address = addr;
    assign bus0.DataIn  = din;

    mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) dut2 (.Clock(clk), .Reset(rst), .bus(bus2));
    mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (.Clock(clk), .Reset(rst), .bus(bus0));

    // Reference: plain word array, last read value and sticky overrun.
    logic [31:0] ref_mem [2**AW];
    logic [31:0] exp_dout;
    logic        exp_ovr;

    int n_cmp = 0;
    int n_bad = 0;
    int lat2, lat0, cnt2, cnt0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic note_ready(input int c);
        if (bus2.Ready) begin cnt2++; if (lat2 < 0) lat2 = c; end
        if (bus0.Ready) begin cnt0++; if (lat0 < 0) lat0 = c; end
    endtask

    task automatic check_after(input string tag);
        check_eq({tag, " lat w2"}, 32'(lat2), 32'd4);
        check_eq({tag, " lat w0"}, 32'(lat0), 32'd2);
        check_eq({tag, " ready count w2"}, 32'(cnt2), 32'd1);
        check_eq({tag, " ready count w0"}, 32'(cnt0), 32'd1);
        check_eq({tag, " dout w2"}, bus2.DataOut, exp_dout);
        check_eq({tag, " dout w0"}, bus0.DataOut, exp_dout);
        check_eq({tag, " busy w2"}, 32'(bus2.Busy), 32'd0);
        check_eq({tag, " busy w0"}, 32'(bus0.Busy), 32'd0);
        check_eq({tag, " overrun w2"}, 32'(bus2.Overrun), 32'(exp_ovr));
        check_eq({tag, " overrun w0"}, 32'(bus0.Overrun), 32'(exp_ovr));
    endtask

    // Entered and left just after a falling edge; the strobe rises now.
    task automatic run_txn(input string tag, input bit is_wr, input logic [AW-1:0] a,
                           input logic [31:0] d, input bit hold, input bit scramble);
        lat2 = -1; lat0 = -1; cnt2 = 0; cnt0 = 0;
        addr = a; din = d; rd = !is_wr; wr = is_wr;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            note_ready(c);
            if (c == 1) begin
                check_eq({tag, " busy start w2"}, 32'(bus2.Busy), 32'd1);
                check_eq({tag, " busy start w0"}, 32'(bus0.Busy), 32'd1);
            end
            if (!hold || c >= 6) begin rd = 1'b0; wr = 1'b0; end
            if (scramble) begin addr = AW'($urandom); din = $urandom; end
        end
        if (is_wr) ref_mem[a] = d;
        else       exp_dout = ref_mem[a];
        check_after(tag);
        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_collision(input logic [AW-1:0] a);
        addr = a; din = $urandom; rd = 1'b1; wr = 1'b1;
        @(negedge clk);
        check_eq("collision w2", 32'(bus2.Collision), 32'd1);
        check_eq("collision w0", 32'(bus0.Collision), 32'd1);
        check_eq("collision busy w2", 32'(bus2.Busy), 32'd0);
        check_eq("collision busy w0", 32'(bus0.Busy), 32'd0);
        @(negedge clk);
        check_eq("collision end w2", 32'(bus2.Collision), 32'd0);
        check_eq("collision end w0", 32'(bus0.Collision), 32'd0);
        check_eq("collision ready w2", 32'(bus2.Ready), 32'd0);
        check_eq("collision ready w0", 32'(bus0.Ready), 32'd0);
        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        run_txn("collision readback", 1'b0, a, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " dout w2"}, bus2.DataOut, 32'h0);
        check_eq({tag, " dout w0"}, bus0.DataOut, 32'h0);
        check_eq({tag, " flags w2"},
                 {28'h0, bus2.Ready, bus2.Busy, bus2.Collision, bus2.Overrun}, 32'h0);
        check_eq({tag, " flags w0"},
                 {28'h0, bus0.Ready, bus0.Busy, bus0.Collision, bus0.Overrun}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = 32'h0;
        exp_dout = 32'h0;
        exp_ovr  = 1'b0;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; din = 32'h0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_txn("write 05A", 1'b1, 9'h05A, 32'hDEADBEEF, 1'b0, 1'b0);
        run_txn("read 05A", 1'b0, 9'h05A, 32'h0, 1'b0, 1'b0);
        run_txn("held read", 1'b0, 9'h05A, 32'h0, 1'b1, 1'b0);
        run_txn("unwritten read", 1'b0, 9'h1FF, 32'h0, 1'b0, 1'b1);
        run_collision(9'h05A);

        // Second write edge lands while busy and must be dropped.
        run_txn("write 010", 1'b1, 9'h010, 32'hA5A5_0010, 1'b0, 1'b0);
        lat2 = -1; lat0 = -1; cnt2 = 0; cnt0 = 0;
        addr = 9'h020; din = 32'hB0B0_0020; wr = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            note_ready(c);
            if (c == 1) wr = 1'b0;
            if (c == 2) begin wr = 1'b1; addr = 9'h010; din = 32'hC0C0_C0C0; end
        end
        ref_mem[9'h020] = 32'hB0B0_0020;
        exp_ovr = 1'b1;
        check_after("overrun");
        wr = 1'b0;
        @(negedge clk);
        run_txn("overrun keep 010", 1'b0, 9'h010, 32'h0, 1'b0, 1'b0);
        run_txn("overrun first 020", 1'b0, 9'h020, 32'h0, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 7) == 0)
                run_collision(AW'($urandom_range(0, 31)));
            else
                run_txn($sformatf("rand %0d", t), 1'($urandom), AW'($urandom_range(0, 31)),
                        $urandom, 1'($urandom), 1'($urandom));
        end

        // Reset while the write sits in its wait states.
        addr = 9'h100; din = 32'h12345678; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset mid write");
        rst = 1'b0;
        exp_ovr = 1'b0;
        exp_dout = 32'h0;
        repeat (4) @(negedge clk);
        check_all_zero("after abort");
        run_txn("read 100", 1'b0, 9'h100, 32'h0, 1'b0, 1'b0);

        // A strobe held through reset counts as a fresh request afterwards.
        rst = 1'b1; rd = 1'b1; addr = 9'h05A;
        repeat (2) @(negedge clk);
        exp_dout = 32'h0;
        check_all_zero("reset held strobe");
        rst = 1'b0;
        run_txn("read after reset", 1'b0, 9'h05A, 32'h0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 9, sets the word-address width, giving a 2^ADDR_W x 32-bit array.
REQ-002 Parameter WAIT_CYCLES, default 2, sets the number of wait states inserted before each access; legal range 0..15.
REQ-003 Clock  in  1  sole clock; all state updates on rising edge.
REQ-004 Reset  in  1  one clock; reset is synchronous and active-high.
REQ-005 Read  in  1  read strobe from the CPU control unit; may be held high for several cycles.
REQ-006 Write  in  1  write strobe from the CPU control unit; may be held high for several cycles.
REQ-007 Address  in  ADDR_W  word address, taken from the MAR.
REQ-008 DataIn  in  32  write data, taken from the MDR.
REQ-009 DataOut  out  32  registered read data, driven toward the MDR.
REQ-010 Ready  out  1  one-cycle completion pulse for a read or a write.
REQ-011 Busy  out  1  high while a transaction is in flight.
REQ-012 Collision  out  1  one-cycle pulse when a Read edge and a Write edge arrive together.
REQ-013 Overrun  out  1  sticky flag; a new request edge arrived while Busy was high.

Function
REQ-014 Keep registered copies Read_d and Write_d of the strobes.
- A request is a rising edge only: Read&~Read_d or Write&~Write_d.
- A strobe held high never re-triggers.
REQ-015 FSM states are IDLE, WAIT, ACCESS and DONE.
REQ-016 IDLE behaviour, when exactly one request edge is seen at edge N:
- latch Address, DataIn and the operation;
- load the counter with WAIT_CYCLES;
- go to WAIT, or go to ACCESS when WAIT_CYCLES=0.
REQ-017 WAIT decrements the counter each edge and goes to ACCESS on the edge where the counter is 1.
REQ-018 ACCESS, at its exit edge:
- a write commits the latched data to array[latched address];
- a read loads DataOut from array[latched address];
- the state then goes to DONE.
REQ-019 DONE asserts Ready for exactly one cycle, then returns to IDLE.
- Latency: Ready is high in the cycle following edge N+WAIT_CYCLES+1.
- Default: Ready follows edge N+3.
REQ-020 Busy is high in the WAIT, ACCESS and DONE states and low in IDLE.
REQ-021 Operands are captured only at accept time.
- Changes to Address or DataIn while Busy have no effect.
- DataOut holds its value until the next read's ACCESS edge; writes never change it.
REQ-022 Simultaneous Read and Write edges in IDLE:
- pulse Collision for one cycle;
- perform no access, no Ready and no state change.
REQ-023 A request edge while Busy is dropped and Overrun is set; the in-flight transaction completes unaffected.
REQ-024 A request edge in the same cycle as DONE counts as Busy: it is dropped and Overrun is set.
REQ-025 Address wrap does not occur: every ADDR_W value is a valid location, and no bounds error exists.
REQ-026 A read of a never-written location returns 32'h0 (the array is zero-initialised at elaboration).

Reset
REQ-027 When Reset is high at an edge, the block:
- returns the state to IDLE;
- clears the counter, Read_d and Write_d;
- drives DataOut=0, Ready=0, Busy=0, Collision=0 and Overrun=0.
REQ-028 Reset mid-transaction aborts it: a pending write is not committed, and Ready is not pulsed.
REQ-029 Reset does not clear the array contents.
REQ-030 A strobe that is high during reset is treated as a new request on the first edge after Reset falls.

Verification
REQ-031 Write then read (WAIT_CYCLES=2):
- Write pulse, Address=9'h05A, DataIn=32'hDEADBEEF, accepted at edge 10 -> Ready high after edge 13;
- then Read of 9'h05A -> DataOut=32'hDEADBEEF with Ready in the same cycle.
REQ-032 Held strobe: Read held high for 6 cycles -> exactly one Ready pulse and Overrun stays 0.
REQ-033 Collision: Read and Write rise on the same edge -> Collision=1 for one cycle, Busy stays 0, memory unchanged.
REQ-034 Overrun:
- a second Write edge to 9'h010 while Busy -> Overrun=1 (sticky);
- location 9'h010 keeps its old value;
- the first transaction still completes with one Ready pulse.
REQ-035 Reset mid-write:
- Write 32'h12345678 to 9'h100, Reset asserted in WAIT -> no Ready, all outputs 0;
- a subsequent read of 9'h100 returns its prior value 32'h0.
REQ-036 Zero wait (WAIT_CYCLES=0): a request accepted at edge N -> Ready high after edge N+1.
